// File: rtl/registers.sv
// -----------------------------------------------------------------------------
// registers -- 2**ADDR_WIDTH x DATA_WIDTH register file, two async read ports,
// one synchronous write port. Register 0 is hard-wired to zero.
//
// Ports:
//   Clk            in   clock; all state updates on its rising edge
//   Rst            in   synchronous active-high reset, clears every register
//   ReadRegister1  in   read port 1 index
//   ReadRegister2  in   read port 2 index
//   WriteRegister  in   write index (index 0 discards the write)
//   WriteData      in   write value
//   RegWrite       in   write enable, sampled on the rising edge
//   ReadData1      out  contents at ReadRegister1 (combinational)
//   ReadData2      out  contents at ReadRegister2 (combinational)
//
// Build option:
//   REGISTERS_BYPASS_EN  when defined, a read whose index matches an active
//                        write shows WriteData in the same cycle (never for
//                        index 0, never while Rst is high).
// -----------------------------------------------------------------------------
module registers #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic                                wr_en;

    // A write only lands when enabled and not aimed at the zero register.
    assign wr_en = RegWrite && (WriteRegister != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[WriteRegister] = WriteData;
        // Keeps entry 0 a constant so it never needs a read-side mask.
        regs_d[0] = '0;
    end

    // Reset wins over a coincident write.
    always_ff @(posedge Clk) begin
        if (Rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

`ifdef REGISTERS_BYPASS_EN
    logic fwd_en;

    // Forwarding is suppressed during reset so reads show the pre-reset
    // contents up to the edge; wr_en already excludes index 0.
    assign fwd_en = wr_en && !Rst;

    assign ReadData1 = (fwd_en && ReadRegister1 == WriteRegister) ? WriteData
                                                                  : regs_q[ReadRegister1];
    assign ReadData2 = (fwd_en && ReadRegister2 == WriteRegister) ? WriteData
                                                                  : regs_q[ReadRegister2];
`else
    assign ReadData1 = regs_q[ReadRegister1];
    assign ReadData2 = regs_q[ReadRegister2];
`endif

endmodule

// File: tb/tb_registers.sv
// -----------------------------------------------------------------------------
// tb_registers -- directed plus randomized bench for the register file.
// Expected reads come from a plain array model updated per the write/reset
// rules; forwarding expectations follow REGISTERS_BYPASS_EN in this build.
// -----------------------------------------------------------------------------
module tb_registers;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] ReadData1, ReadData2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [32];

    registers #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    always #5 Clk = ~Clk;

    // Value a read port should show before the coming edge.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGISTERS_BYPASS_EN
        if (RegWrite && !Rst && WriteRegister == a) return WriteData;
`endif
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, check both reads before the
    // rising edge, then let the edge happen and update the model.
    task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input string tag);
        @(negedge Clk);
        Rst = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        #1;
        check({tag, "/rd1"}, ReadData1, exp_read(r1));
        check({tag, "/rd2"}, ReadData2, exp_read(r2));
        @(posedge Clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else if (we && wa != 0) begin
            mem[wa] = wd;
        end
    endtask

    initial begin
        logic [AW-1:0] wa, r1, r2;
        logic          we, rst;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        Rst = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        @(posedge Clk);

        // Post-reset scan: every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, AW'(i), AW'(31 - i), "rst_scan");
            check("rst_scan_const", ReadData1, 32'h0);
        end

        // Basic write then read; port 2 on index 0.
        step(0, 1, 1, 32'd5, 0, 0, "wr1");
        step(0, 0, 0, 0, 1, 0, "rd1");
        check("rd1_const", ReadData1, 32'd5);

        // Writes to index 0 are discarded.
        step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, "wr0");
        step(0, 0, 0, 0, 0, 0, "rd0");
        check("rd0_const", ReadData1, 32'h0);

        // Disabled write leaves index 31; enabled write lands, both ports read it.
        step(0, 1, 31, 32'h1111_2222, 31, 31, "pre31");
        step(0, 0, 31, 32'hA5A5_A5A5, 31, 31, "nowe31");
        step(0, 0, 0, 0, 31, 31, "rd31a");
        check("rd31a_const", ReadData1, 32'h1111_2222);
        step(0, 1, 31, 32'hA5A5_A5A5, 0, 0, "we31");
        step(0, 0, 0, 0, 31, 31, "rd31b");
        check("rd31b_p1", ReadData1, 32'hA5A5_A5A5);
        check("rd31b_p2", ReadData2, 32'hA5A5_A5A5);

        // Same-cycle read of a register being written.
        step(0, 1, 7, 32'd3, 0, 0, "wr7");
        @(negedge Clk);
        RegWrite = 1; WriteRegister = 7; WriteData = 32'd9; ReadRegister1 = 7; ReadRegister2 = 0;
        #1;
`ifdef REGISTERS_BYPASS_EN
        check("fwd7", ReadData1, 32'd9);
`else
        check("fwd7", ReadData1, 32'd3);
`endif
        check("fwd7_r0", ReadData2, 32'h0);
        @(posedge Clk);
        mem[7] = 32'd9;
        step(0, 0, 0, 0, 7, 7, "after7");
        check("after7_const", ReadData1, 32'd9);

        // Reset beats a coincident write; before the edge old contents show.
        step(0, 1, 4, 32'h77, 0, 0, "wr4");
        step(1, 1, 4, 32'h1234, 4, 7, "rstwr4");
        check("rstwr4_pre", ReadData1, 32'h77);
        step(0, 0, 0, 0, 4, 7, "rd4");
        check("rd4_const", ReadData1, 32'h0);
        check("rd7_const", ReadData2, 32'h0);

        // Randomized traffic with occasional reset and address collisions.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            we  = $urandom_range(0, 2) != 0;
            wa  = AW'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            step(rst, we, wa, $urandom, r1, r2, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/registers.md
REGISTERS -- requirements
Module: registers

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the register word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, the register index width, giving 2**ADDR_WIDTH = 32 registers.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: the synchronous, active-high reset.
REQ-006 The block SHALL have port ReadRegister1, input, ADDR_WIDTH bits: the read port 1 index.
REQ-007 The block SHALL have port ReadRegister2, input, ADDR_WIDTH bits: the read port 2 index.
REQ-008 The block SHALL have port WriteRegister, input, ADDR_WIDTH bits: the write index.
REQ-009 The block SHALL have port WriteData, input, DATA_WIDTH bits: the write value.
REQ-010 The block SHALL have port RegWrite, input, 1 bit: the write enable, active high.
REQ-011 The block SHALL have port ReadData1, output, DATA_WIDTH bits: the contents at ReadRegister1.
REQ-012 The block SHALL have port ReadData2, output, DATA_WIDTH bits: the contents at ReadRegister2.

Function
REQ-013 The block SHALL hold 32 DATA_WIDTH-bit registers, indexed 0..31.
REQ-014 On a rising Clk edge with Rst=0, RegWrite=1 and WriteRegister != 0, the block SHALL store WriteData into the indexed register, with 1-cycle write latency.
REQ-015 The block SHALL ignore writes when RegWrite=0 and leave all contents unchanged.
REQ-016 Register 0 SHALL always read 0, and writes to index 0 SHALL be discarded.
REQ-017 ReadData1 and ReadData2 SHALL be combinational (asynchronous) reads of the indexed register, changing within the same cycle the index changes.
REQ-018 The two read ports SHALL be independent: both may address the same register or both may address the write target.
REQ-019 When a read index equals a WriteRegister being written in the same cycle, the read port SHALL return the old value until the edge, unless REQ-025 applies.
REQ-020 Data SHALL be stored and returned unmodified, with no sign or zero manipulation.
REQ-021 The block SHALL have no handshake; the enable is sampled only on the rising Clk edge.

Reset
REQ-022 On a rising Clk edge with Rst=1, all 32 registers SHALL clear to 0; both read outputs then read 0.
REQ-023 Rst SHALL take priority over a simultaneous write, so the write is lost.
REQ-024 Asserting Rst mid-sequence SHALL affect state only at the next rising edge; before that edge, reads SHALL show the pre-reset contents.

Configuration
REQ-025 Macro REGISTERS_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: when RegWrite=1, Rst=0, WriteRegister != 0 and a read index equals WriteRegister, that ReadData SHALL show WriteData combinationally in the same cycle.
- Undefined: no forwarding; reads return stored contents only, per REQ-019.
- Index 0 SHALL never be forwarded in either build.

Verification
REQ-026 Apply Rst=1 for 1 edge, then read indices 0..31 on both ports -> all outputs are 0.
REQ-027 Drive RegWrite=1, WriteRegister=1, WriteData=5 across a rising edge, deassert RegWrite, then set ReadRegister1=1 -> ReadData1=5; ReadData2 at index 0 = 0.
REQ-028 Write 0xFFFFFFFF to index 0 -> ReadData1 at index 0 stays 0.
REQ-029 Write 0xA5A5A5A5 to index 31 with RegWrite=0 -> index 31 still reads its prior value; repeat with RegWrite=1 -> reads 0xA5A5A5A5 on both ports at once.
REQ-030 With index 7 holding 3, drive RegWrite=1, WriteRegister=7, WriteData=9 with ReadRegister1=7 before the edge -> reads 9 with REGISTERS_BYPASS_EN defined, 3 without; both builds read 9 after the edge.
REQ-031 Drive Rst=1 and a write of 0x1234 to index 4 on the same edge -> index 4 reads 0.
